// File: rtl/sobol_pkg.sv
// Shared types and widths for the Sobol sample path: unsigned INT32 in, unsigned FP16 out.
package sobol_pkg;

  localparam int FP_EXP_W  = 4;
  localparam int FP_MANT_W = 12;
  localparam int INT_W     = 32;

  typedef struct packed {
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp16_t;

endpackage

// File: rtl/INT32_to_FP16.sv
// Combinational INT32 -> FP16: exponent is the leading-one index (min 11, kept mod 16),
// mantissa is the 12 bits starting at that leading one.
module INT32_to_FP16
  import sobol_pkg::*;
(
  input  logic [INT_W-1:0] int_i,
  output fp16_t            fp_o
);

  logic [4:0] mso;

  always_comb begin
    mso = 5'd11;
    for (int b = 12; b < INT_W; b++) begin
      if (int_i[b]) mso = 5'(b);
    end
    fp_o.exp  = mso[FP_EXP_W-1:0];
    fp_o.mant = FP_MANT_W'(int_i >> (mso - 5'd11));
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sobol_fp16_scheduler.sv
// Round-robin share of one INT32->FP16 converter across NUM_REQ Sobol lanes,
// two registered stages (capture, convert) feeding a tagged valid/ready stream.
module sobol_fp16_scheduler
  import sobol_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*INT_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               s1_valid_q;
  logic [INT_W-1:0]   s1_int_q;
  logic [ID_W-1:0]    s1_id_q;
  logic               s2_valid_q;
  fp16_t              s2_fp_q;
  logic [ID_W-1:0]    s2_id_q;

  fp16_t              conv_fp;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               s2_take, s1_adv, grant_en, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id)
  );

  INT32_to_FP16 u_conv (
    .int_i (s1_int_q),
    .fp_o  (conv_fp)
  );

  assign s2_take  = s1_valid_q & (~s2_valid_q | out_ready);
  assign s1_adv   = ~s1_valid_q | s2_take;
  // Grants are masked while reset is held so req_ready reads 0 during reset.
  assign grant_en = en & s1_adv & ~flush & rst_n;
  assign req_ready = grant_en ? grant : '0;
  assign accept   = grant_en & (|req_valid);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_int_q   <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_fp_q    <= '0;
      s2_id_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (accept) begin
          s1_valid_q <= 1'b1;
          s1_int_q   <= req_data[INT_W*int'(grant_id) +: INT_W];
          s1_id_q    <= grant_id;
        end else if (s2_take) begin
          s1_valid_q <= 1'b0;
        end
        if (s2_take) begin
          s2_valid_q <= 1'b1;
          s2_fp_q    <= conv_fp;
          s2_id_q    <= s1_id_q;
        end else if (out_ready) begin
          s2_valid_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_fp_q;
  assign out_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_sobol_fp16_scheduler.sv
// Randomised and directed bench for sobol_fp16_scheduler against a FIFO-level reference model.
module tb_sobol_fp16_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           flush = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [15:0]    out_data;
  logic [IDW-1:0] out_id;
  logic           busy;

  sobol_fp16_scheduler #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: a FIFO of at most two samples; a sample becomes visible
  // at the output from the second cycle after its capture onward.
  typedef struct {
    logic [15:0] fp;
    int          id;
    int          cyc;
  } item_t;

  item_t pq[$];
  int    m_ptr = 0;
  int    cyc = 0;
  int    last_grant = -1;

  function automatic logic [15:0] ref_conv(input logic [31:0] x);
    longint unsigned v;
    int e;
    v = 64'(x);
    e = 11;
    while (e < 31 && v >= (64'd1 << (e + 1))) e++;
    return {4'(e % 16), 12'((v >> (e - 11)) % 4096)};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_lane(input int i, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_data[32*i +: 32] = d;
  endtask

  function automatic logic [31:0] rand_data();
    return $urandom >> $urandom_range(0, 31);
  endfunction

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    int exp_g;
    logic [N-1:0] exp_rr;
    bit vis;
    bit can;
    #1;
    can = en && !flush && (pq.size() < 2 || out_ready);
    exp_g = can ? rr_pick(req_valid, m_ptr) : -1;
    exp_rr = '0;
    if (exp_g >= 0) exp_rr[exp_g] = 1'b1;
    vis = (pq.size() > 0) && (pq[0].cyc + 1 < cyc);
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    check("out_valid", 32'(out_valid), 32'(vis));
    check("busy", 32'(busy), 32'(pq.size() > 0));
    if (vis) begin
      check("out_data", 32'(out_data), 32'(pq[0].fp));
      check("out_id", 32'(out_id), 32'(pq[0].id));
    end
    @(posedge clk);
    if (flush) begin
      pq.delete();
    end else begin
      if (vis && out_ready) begin
        $display("[TB] cyc %0d out id=%0d data=0x%04h", cyc, pq[0].id, pq[0].fp);
        void'(pq.pop_front());
      end
      if (exp_g >= 0) begin
        pq.push_back('{ref_conv(req_data[32*exp_g +: 32]), exp_g, cyc});
        m_ptr = (exp_g + 1) % N;
      end
    end
    last_grant = exp_g;
    cyc++;
    @(negedge clk);
  endtask

  task automatic retire();
    if (last_grant >= 0) req_valid[last_grant] = 1'b0;
  endtask

  task automatic refill_all();
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) set_lane(i, rand_data());
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_id"}, 32'(out_id), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    pq.delete();
    m_ptr = 0;
    last_grant = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Conversion: three samples from lane 0, two-cycle latency each
    en = 1'b1;
    out_ready = 1'b1;
    set_lane(0, 32'h0000_1234); tick(); retire();
    check("conv_latency", 32'(out_valid), 32'd0);
    set_lane(0, 32'h0000_0005); tick(); retire();
    check("conv_a", 32'(out_data), 32'hC91A);
    check("conv_a_id", 32'(out_id), 32'd0);
    set_lane(0, 32'h8000_0000); tick(); retire();
    check("conv_b", 32'(out_data), 32'hB005);
    tick(); retire();
    check("conv_c", 32'(out_data), 32'hF800);
    check("conv_c_valid", 32'(out_valid), 32'd1);
    tick(); tick();

    // Async reset mid-stream, then fairness starting from lane 0
    refill_all();
    out_ready = 1'b0;
    tick(); retire(); refill_all();
    tick(); retire(); refill_all();
    async_reset("arst");
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check("fair_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      if (i >= 2) check("fair_stream", 32'(out_valid), 32'd1);
      tick(); retire(); refill_all();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Sparse requests with ptr at 2
    set_lane(1, rand_data());
    #1 check("sparse_pre", 32'(req_ready), 32'b0010);
    tick(); retire();
    set_lane(1, rand_data());
    set_lane(3, rand_data());
    #1 check("sparse_first", 32'(req_ready), 32'b1000);
    tick(); retire();
    #1 check("sparse_second", 32'(req_ready), 32'b0010);
    tick(); retire();
    refill_all();
    #1 check("sparse_ptr", 32'(req_ready), 32'b0100);
    tick(); retire();
    req_valid = '0;
    tick(); tick(); tick();

    // Backpressure for 5 cycles, then release
    refill_all();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) begin
        #1 check("bp_block", 32'(req_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
      end
      tick(); retire(); refill_all();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); retire(); refill_all();
    end

    // Flush with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); retire(); refill_all();
    end
    flush = 1'b1;
    tick(); retire();
    flush = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);

    // Enable low: queued data drains, no grants
    for (int i = 0; i < 3; i++) begin
      tick(); retire(); refill_all();
    end
    en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("en_block", 32'(req_ready), 32'd0);
      tick();
    end
    check("en_drained", 32'(busy), 32'd0);

    // Randomised traffic with one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < N; l++) begin
        if (!req_valid[l] && $urandom_range(0, 99) < 40) set_lane(l, rand_data());
      end
      en = ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 70);
      if (i == 200) begin
        async_reset("rand_rst");
      end else begin
        tick(); retire();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobol_fp16_scheduler.md
# sobol_fp16_scheduler

Shares one INT32-to-FP16 converter among `NUM_REQ` Sobol dimension lanes. Each cycle a round-robin arbiter grants one valid lane. The granted INT32 sample goes through a two-stage registered pipeline (capture, then convert) and comes out as a tagged FP16 word on a valid/ready stream. The block sits between the per-dimension Sobol generators and the downstream sample consumer.

## Interface
- `NUM_REQ`, 4: number of requesting lanes, range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: lane-id width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: when low, no new grants are issued; in-flight data still drains.
- `flush` input 1: synchronous clear of both pipeline stages; the round-robin pointer is kept.
- `req_valid` input `NUM_REQ`: lane i has a sample.
- `req_data` input `NUM_REQ*32`: lane i sample is at `[32*i +: 32]`, unsigned INT32.
- `req_ready` output `NUM_REQ`: one-hot grant; lane i sample is consumed when `req_valid[i] & req_ready[i]`.
- `out_valid` output 1: `out_data` and `out_id` are valid.
- `out_ready` input 1: downstream accepts.
- `out_data` output 16: `{exp[3:0], mant[11:0]}`, no sign bit.
- `out_id` output `ID_W`: lane that produced `out_data`.
- `busy` output 1: `s1_valid | s2_valid`.

## Operation
- Conversion rule (the codebase FP16 scheme):
  - MSO = index of the most significant one, clamped to a minimum of 11.
  - `exp = MSO[3:0]`, so MSO ≥ 16 wraps modulo 16.
  - `mant = x[MSO -: 12]`.
  - Inputs below 2^12 give exp = 11 and mant = x[11:0].
- Arbitration:
  - Round-robin pointer `ptr` (`ID_W` bits).
  - Grant goes to the first valid lane at or after `ptr`, searching cyclically.
  - After an accepted grant to lane g: `ptr <= (g+1) mod NUM_REQ`.
  - No accepted grant: `ptr` holds.
- Stage S1: registers `s1_valid`, `s1_int` (32 bits), `s1_id`.
  - Loads on an accepted grant.
  - Advance condition: `s1_adv = !s1_valid | s2_take`.
  - Grant is issued only when `en & s1_adv`.
- Stage S2: registers `s2_valid`, `s2_fp` (16 bits), `s2_id`.
  - Loads the converted `s1_int` when `s2_take = s1_valid & (!s2_valid | out_ready)`.
  - `s2_valid` clears on an output handshake when S1 is empty.
- Outputs are driven directly from S2 registers; there is no combinational path from `req_*` to `out_*`.
- Simultaneous events:
  - `flush` overrides grants and handshakes in the same cycle: `req_ready` is 0 and no output is consumed.
  - Reset mid-stream discards all in-flight samples.
- Handshake contract on `out_*`: while `out_valid & !out_ready`, `out_data` and `out_id` hold stable.

## Timing
- Reset values:
  - `ptr` = 0.
  - `s1_valid` = `s2_valid` = 0, so `out_valid` = 0 and `busy` = 0.
  - `out_data` = 0, `out_id` = 0, `req_ready` = 0.
- Latency: a sample accepted at edge N appears on `out_valid` after edge N+1, i.e. 2 cycles from the request handshake.
- Throughput: 1 sample/cycle while `out_ready` stays high.
- Backpressure: with `out_ready` low, at most 2 samples are held. `req_ready` drops the cycle after S1 fills.
- `req_ready` is combinational from `req_valid`, `ptr`, `en`, `flush` and stage state.
- Request contract: a lane must hold `req_valid` and `req_data` stable until granted.

## Structure
- Shared package `sobol_pkg`:
  - `FP_EXP_W` = 4, `FP_MANT_W` = 12, `INT_W` = 32.
  - Typedef `fp16_t` as a packed `{exp, mant}` struct.
- Sub-modules:
  - S1→S2 conversion: instance of the codebase's existing `INT32_to_FP16` converter, purely combinational.
  - One natural sub-module: `rr_arbiter` (parameterised `NUM_REQ`; inputs `req` and `ptr`; outputs one-hot `grant` and encoded `grant_id`).

## Test plan
- **Conversion**: lane 0 sends 0x0000_1234, then 0x0000_0005, then 0x8000_0000, with `out_ready`=1.
  - Expected: 0xC91A, 0xB005, 0xF800, each with `out_id`=0.
  - Each output arrives 2 cycles after its handshake.
- **Fairness**: all 4 lanes held valid for 8 cycles.
  - Expected: grant order 0,1,2,3,0,1,2,3 and 8 outputs on consecutive cycles.
- **Sparse requests**: lanes 1 and 3 valid with `ptr`=2.
  - Expected: grant 3 first, then 1; `ptr` ends at 2.
- **Backpressure**: `out_ready`=0 for 5 cycles during a stream.
  - Expected: `busy`=1, exactly 2 samples held, `out_data` stable.
  - On release, no loss or duplication; ordering is preserved.
- **Flush and enable**: `flush` pulsed with both stages full.
  - Expected: `out_valid`=0 the next cycle and `busy`=0.
  - With `en`=0, `req_ready` stays 0 while queued data drains.
- **Async reset**: `rst_n` asserted mid-cycle during traffic.
  - Expected: outputs go to their reset values immediately, and the first grant after release goes to lane 0.
